// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 generator/checker: an MSB-first Galois LFSR that absorbs one
// message bit per enabled clock and exposes the running remainder every cycle.
// The serial data input is named serial_bit because "bit" is a reserved word.
module crc8_serial #(
    parameter logic [7:0] POLY        = 8'h07,
    parameter logic [7:0] INIT        = 8'h00,
    parameter logic [7:0] XOR_OUT     = 8'h00,
    parameter bit         REFLECT_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_bit,
    input  logic       shift,
    output logic [7:0] result
);

    localparam int unsigned CRC_W = 8;

    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_nxt;
    logic [CRC_W-1:0] xored;
    logic [CRC_W-1:0] reversed;
    logic             fb;

    // Next remainder: one LFSR step when shift is high, otherwise hold.
    always_comb begin
        crc_nxt = crc_reg;
        fb      = serial_bit ^ crc_reg[CRC_W-1];
        if (shift) begin
            crc_nxt = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
        end
    end

    // CRC register; synchronous active-low reset wins over shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_reg <= INIT;
        end else begin
            crc_reg <= crc_nxt;
        end
    end

    // Output mapping depends only on crc_reg, so result is valid right after the edge.
    always_comb begin
        xored    = crc_reg ^ XOR_OUT;
        reversed = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            reversed[i] = xored[CRC_W-1-i];
        end
        result = REFLECT_OUT ? reversed : xored;
    end

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial (default CRC-8/SMBUS parameters).
module tb_crc8_serial;

    typedef struct {
        logic       rst;
        logic       shift;
        logic       sbit;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       serial_bit;
    logic       shift;
    logic [7:0] result;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];
    logic hist[$];

    crc8_serial dut (
        .clk       (clk),
        .rst       (rst),
        .serial_bit(serial_bit),
        .shift     (shift),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, by plain long division.
    function automatic logic [7:0] ref_crc(input logic q[$]);
        logic [8:0] r;
        logic       b;
        r = 9'h000;
        for (int i = 0; i < q.size() + 8; i++) begin
            b = (i < q.size()) ? q[i] : 1'b0;
            r = {r[7:0], b};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic add(input logic r, input logic s, input logic b, input logic [7:0] e);
        vec_t v;
        v.rst = r; v.shift = s; v.sbit = b; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic b);
        @(negedge clk);
        rst = r; shift = s; serial_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL %s: result=%02h expected=%02h", name, result, exp);
        end
    endtask

    task automatic feed_byte(input logic [7:0] by);
        for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, by[i]);
    endtask

    initial begin
        logic [7:0] seq[8];
        logic [7:0] bits2d;
        logic [7:0] msg[9];
        logic [7:0] e;
        logic       r, s, b;

        rst = 1'b0; shift = 1'b0; serial_bit = 1'b0;
        seq = '{8'h07, 8'h0E, 8'h1B, 8'h31, 8'h62, 8'hC3, 8'h81, 8'h05};
        bits2d = 8'h2D;

        // Reset beats shift, then 0x2D LSB first.
        add(1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) add(1'b1, 1'b1, bits2d[i], seq[i]);
        // Hold with bit toggling, then one more 1 bit.
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'(i % 2 == 0), 8'h05);
        add(1'b1, 1'b1, 1'b1, 8'h0D);
        // Reset mid-message and replay.
        add(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, bits2d[i], seq[i]);
        add(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) add(1'b1, 1'b1, bits2d[i], seq[i]);
        // All-zero input keeps zero; a single 1 then gives the polynomial.
        add(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) add(1'b1, 1'b1, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 8'h07);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].shift, vecs[i].sbit);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Standard check value over "123456789", then the appended CRC.
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        step(1'b0, 1'b0, 1'b0);
        check("std_reset", 8'h00);
        foreach (msg[i]) feed_byte(msg[i]);
        check("std_check", 8'hF4);
        feed_byte(8'hF4);
        check("std_residue", 8'h00);

        // Randomized traffic with gaps and occasional resets against the model.
        step(1'b0, 1'b0, 1'b0);
        hist.delete();
        for (int n = 0; n < 2000; n++) begin
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 2) != 0);
            b = 1'($urandom);
            step(r, s, b);
            if (!r) hist.delete();
            else if (s) hist.push_back(b);
            e = ref_crc(hist);
            check($sformatf("rand%0d", n), e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc8_serial.md
Name: crc8_serial

Overview:
- Bit-serial CRC-8 generator/checker. Absorbs one message bit per clock while `shift` is high, and exposes the running CRC register on `result` every cycle.
- Sits beside serial links (UART/SPI/SMBus-style framers), which feed it payload bits in transmit order and read the CRC after the last bit.
- Default configuration is CRC-8/SMBUS: polynomial 0x07, init 0x00, no reflection, xorout 0x00.

Parameters:
- POLY, 8'h07, generator polynomial without the implicit x^8 term (x^8+x^2+x+1).
- INIT, 8'h00, value loaded into the CRC register on reset.
- XOR_OUT, 8'h00, constant XORed onto the register to form `result`.
- REFLECT_OUT, 0, when 1 `result` is bit-reversed (after XOR_OUT) for LSB-first CRC conventions.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous reset, active-low; sampled on the rising edge of clk.
- bit, input, 1, serial message bit; sampled only when shift=1.
- shift, input, 1, advance enable; 1 = absorb `bit` this edge, 0 = hold.
- result, output, 8, current CRC: crc_reg ^ XOR_OUT, optionally reflected.

Behaviour:
- State: 8-bit register crc_reg. No other state.
- Reset: if rst==0 at a rising edge, crc_reg <= INIT. Reset has priority over shift.
  - After reset, result = f(INIT), i.e. 8'h00 with default parameters.
  - Reset mid-message discards all accumulated state.
- Shift step (rst==1, shift==1), MSB-first Galois LFSR:
  - fb = bit ^ crc_reg[7]
  - crc_reg <= {crc_reg[6:0],1'b0} ^ (fb ? POLY : 8'h00)
- Hold (rst==1, shift==0): crc_reg unchanged. Gaps of any length between bits are allowed.
- Latency:
  - result is a registered function of crc_reg with no extra pipeline stage.
  - It reflects the bit absorbed at edge N immediately after edge N, so it is valid one cycle after the bit is presented.
- Output logic: result = REFLECT_OUT ? reverse(crc_reg ^ XOR_OUT) : (crc_reg ^ XOR_OUT). The output logic is purely combinational from crc_reg, with no combinational path from bit or shift.
- Bit ordering is the caller's responsibility. The block processes bits in arrival order; for standard byte CRCs, feed each byte MSB first.
- Checking mode: feeding message bits followed by the 8 CRC bits (MSB first, default parameters) leaves result == 8'h00 when the data is error-free.
- X/undriven inputs: when shift is unknown, the behaviour is unspecified. Benches must drive shift to a known value from reset release onward.
- No handshake, overflow or wrap conditions exist. The register is free-running modulo the polynomial.

Test Plan:
1. Reset: drive rst=0 for one edge with shift=1 and bit=1 -> result=8'h00 after the edge (reset wins over shift).
2. Bit sequence: after reset, feed 8'h2D LSB first with shift=1 (bits 1,0,1,1,0,1,0,0) -> result after each edge is 07, 0E, 1B, 31, 62, C3, 81, 05.
3. Hold: after step 2, drive shift=0 for 5 cycles with bit toggling -> result stays 8'h05. Then shift in bit=1 -> result 8'h0D.
4. Standard check: ASCII "123456789", each byte MSB first (72 bits) -> result=8'hF4. Then append 8'hF4 MSB first -> result=8'h00.
5. Reset mid-operation: after 4 bits of step 2 (result 31), assert rst=0 for one edge -> result 00. Then replay step 2 -> the same sequence, ending at 05.
6. All-zero input: after reset, shift in 16 zero bits -> result stays 8'h00 throughout. A single 1 bit then gives result 8'h07.
